// File: rtl/qupls_fpu_rs_queue_pkg.sv
// qupls_fpu_rs_queue_pkg: shared types and helpers for the FPU reservation station queue
package qupls_fpu_rs_queue_pkg;
   localparam int FPU_RS_NOPS = 4;
   localparam int FPU_RS_AGEW = 5;
   typedef logic [63:0] value_t;
   typedef logic [7:0] pregno_t;
   typedef logic [5:0] aregno_t;
   typedef logic [4:0] rob_ndx_t;
   typedef logic [2:0] checkpt_ndx_t;
   typedef logic [31:0] pc_address_t;
   localparam value_t value_zero = '0;
   localparam pc_address_t RSTPC = 32'hFFFD0000;
   typedef enum logic [6:0] {OP_NOP = 7'h0B, OP_FPU = 7'h2C} opcode_t;
   typedef struct packed {
      logic [28:0] imm;
      aregno_t Ra;
      aregno_t Rd;
      opcode_t opcode;
   } instruction_t;
   typedef struct packed {
      instruction_t instr;
      pc_address_t pc;
      checkpt_ndx_t cp;
      pregno_t Rt;
      aregno_t aRt;
      logic aRtz;
      value_t argI;
      logic cpytgt;
      logic vec;
      logic multicycle;
   } rob_entry_t;
   typedef struct packed {
      value_t val;
      logic v;
      pregno_t tag;
   } fpu_rs_op_t;
   typedef struct packed {
      logic valid;
      logic [FPU_RS_AGEW-1:0] age;
      fpu_rs_op_t [FPU_RS_NOPS-1:0] ops;
      value_t argM;
      value_t argI;
      rob_ndx_t id;
      pregno_t Rt;
      aregno_t aRt;
      logic aRtz;
      instruction_t instr;
      pc_address_t pc;
      checkpt_ndx_t cp;
      logic [7:0] cptgt;
      logic multicycle;
   } fpu_rs_entry_t;
   // Vector ops also target lanes whose mask byte, selected by Ra[2:0], is clear.
   function automatic logic [7:0] fnCptgt(input rob_entry_t r, input value_t m);
      value_t s;
      s = m >> {r.instr.Ra[2:0], 3'h0};
      return r.vec ? {8{r.cpytgt}} | ~s[7:0] : {8{r.cpytgt}};
   endfunction
endpackage

// File: rtl/qupls_rs_age_select.sv
// qupls_rs_age_select: picks the oldest ready entry; ages are a modulo-2N sequence.
module qupls_rs_age_select #(
   parameter int N = 4,
   parameter int AW = 5
) (
   input  logic [N-1:0]         rdy,
   input  logic [N-1:0][AW-1:0] age,
   output logic [N-1:0]         sel,
   output logic                 selV
);
   function automatic logic older(input logic [AW-1:0] a, input logic [AW-1:0] b);
      int d;
      d = int'(b) - int'(a);
      d = d < 0 ? d + 2 * N : d;
      return d > 0 && d < N;
   endfunction
   always_comb begin
      sel = '0;
      for (int i = 0; i < N; i++) begin
         sel[i] = rdy[i];
         for (int j = 0; j < N; j++)
            if (j != i && rdy[j] && !older(age[i], age[j])) sel[i] = 1'b0;
      end
      selV = |rdy;
   end
endmodule

// File: rtl/qupls_fpu_rs_queue.sv
// qupls_fpu_rs_queue: multi-entry FPU reservation station with result-bus snooping.
// QUPLS_FPU_RS_BYPASS_EN lets a fully-ready dispatch issue directly when the queue has nothing ready.
import qupls_fpu_rs_queue_pkg::*;
module qupls_fpu_rs_queue #(
   parameter int NENTRY = 4,
   parameter int NBYP = 2,
   parameter int NOPS = FPU_RS_NOPS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        disp_v,
   output logic                        disp_rdy,
   input  rob_ndx_t                    disp_rndx,
   input  rob_entry_t                  disp_rob,
   input  value_t [NOPS-1:0]           disp_val,
   input  logic [NOPS-1:0]             disp_vld,
   input  pregno_t [NOPS-1:0]          disp_tag,
   input  value_t                      disp_argM,
   input  logic [NBYP-1:0]             byp_v,
   input  pregno_t [NBYP-1:0]          byp_tag,
   input  value_t [NBYP-1:0]           byp_val,
   input  logic                        flush,
   input  checkpt_ndx_t                flush_cp,
   input  logic                        fu_idle,
   output logic                        iss_v,
   output rob_ndx_t                    id,
   output value_t                      argA,
   output value_t                      argB,
   output value_t                      argC,
   output value_t                      argT,
   output value_t                      argM,
   output value_t                      argI,
   output pregno_t                     Rt,
   output aregno_t                     aRt,
   output logic                        aRtz,
   output instruction_t                instr,
   output pc_address_t                 pc,
   output checkpt_ndx_t                cp,
   output logic [7:0]                  cptgt,
   output logic                        sc_done,
   output logic [$clog2(NENTRY+1)-1:0] count
);
   localparam int CW = $clog2(NENTRY + 1);
   localparam int IW = $clog2(NENTRY);
   fpu_rs_entry_t q [NENTRY];
   fpu_rs_entry_t dEnt, iEnt;
   logic [NENTRY-1:0] rdy, sel;
   logic [NENTRY-1:0][FPU_RS_AGEW-1:0] age;
   logic [IW-1:0] freeNdx, selNdx;
   logic [FPU_RS_AGEW-1:0] seq;
   logic selV, accept, dFlush, iFlush, doIss, byp;

   always_comb begin
      count = '0;
      freeNdx = '0;
      for (int i = NENTRY - 1; i >= 0; i--) begin
         rdy[i] = q[i].valid;
         for (int k = 0; k < NOPS; k++) rdy[i] = rdy[i] & q[i].ops[k].v;
         age[i] = q[i].age;
         count = count + CW'(q[i].valid);
         if (!q[i].valid) freeNdx = IW'(i);
      end
   end

   qupls_rs_age_select #(.N(NENTRY), .AW(FPU_RS_AGEW)) uSel (
      .rdy(rdy),
      .age(age),
      .sel(sel),
      .selV(selV)
   );

   always_comb begin
      selNdx = '0;
      for (int i = 0; i < NENTRY; i++) if (sel[i]) selNdx = IW'(i);
   end

   // Incoming entry, with operands woken by a result bus in the dispatch cycle.
   always_comb begin
      dEnt = '0;
      dEnt.valid = 1'b1;
      dEnt.age = seq;
      dEnt.id = disp_rndx;
      dEnt.argM = disp_argM;
      dEnt.argI = disp_rob.argI;
      dEnt.Rt = disp_rob.Rt;
      dEnt.aRt = disp_rob.aRt;
      dEnt.aRtz = disp_rob.aRtz;
      dEnt.instr = disp_rob.instr;
      dEnt.pc = disp_rob.pc;
      dEnt.cp = disp_rob.cp;
      dEnt.cptgt = fnCptgt(disp_rob, disp_argM);
      dEnt.multicycle = disp_rob.multicycle;
      for (int k = 0; k < NOPS; k++) begin
         dEnt.ops[k].val = disp_val[k];
         dEnt.ops[k].v = disp_vld[k];
         dEnt.ops[k].tag = disp_tag[k];
         for (int b = NBYP - 1; b >= 0; b--)
            if (!disp_vld[k] && byp_v[b] && byp_tag[b] == disp_tag[k]) begin
               dEnt.ops[k].val = byp_val[b];
               dEnt.ops[k].v = 1'b1;
            end
      end
   end

   assign disp_rdy = count != CW'(NENTRY);
   assign accept = disp_v && disp_rdy;
   assign dFlush = flush && disp_rob.cp == flush_cp;
   assign iFlush = flush && q[selNdx].cp == flush_cp;

`ifdef QUPLS_FPU_RS_BYPASS_EN
   always_comb begin
      byp = !selV && fu_idle && accept && !dFlush;
      for (int k = 0; k < NOPS; k++) byp = byp & dEnt.ops[k].v;
   end
`else
   assign byp = 1'b0;
`endif

   assign iEnt = byp ? dEnt : q[selNdx];
   assign doIss = byp || (fu_idle && selV && !iFlush);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NENTRY; i++) q[i] <= '0;
         seq <= '0;
         iss_v <= 1'b0;
         sc_done <= 1'b0;
         id <= '0;
         argA <= value_zero;
         argB <= value_zero;
         argC <= value_zero;
         argT <= value_zero;
         argM <= value_zero;
         argI <= value_zero;
         Rt <= '0;
         aRt <= '0;
         aRtz <= 1'b1;
         instr <= instruction_t'({41'd0, OP_NOP});
         pc <= RSTPC;
         cp <= '0;
         cptgt <= '0;
      end
      else begin
         for (int i = 0; i < NENTRY; i++) begin
            for (int k = 0; k < NOPS; k++)
               for (int b = NBYP - 1; b >= 0; b--)
                  if (q[i].valid && !q[i].ops[k].v && byp_v[b] && byp_tag[b] == q[i].ops[k].tag) begin
                     q[i].ops[k].val <= byp_val[b];
                     q[i].ops[k].v <= 1'b1;
                  end
            if ((fu_idle && sel[i]) || (flush && q[i].cp == flush_cp)) q[i].valid <= 1'b0;
         end
         if (accept && !dFlush && !byp) q[freeNdx] <= dEnt;
         if (accept) seq <= seq == FPU_RS_AGEW'(2 * NENTRY - 1) ? '0 : seq + 1'b1;
         iss_v <= doIss;
         sc_done <= doIss && (!iEnt.multicycle || &iEnt.cptgt);
         if (doIss) begin
            id <= iEnt.id;
            argA <= iEnt.ops[0].val;
            argB <= iEnt.ops[1].val;
            argC <= iEnt.ops[2].val;
            argT <= iEnt.ops[3].val;
            argM <= iEnt.argM;
            argI <= iEnt.argI;
            Rt <= iEnt.Rt;
            aRt <= iEnt.aRt;
            aRtz <= iEnt.aRtz;
            instr <= iEnt.instr;
            pc <= iEnt.pc;
            cp <= iEnt.cp;
            cptgt <= iEnt.cptgt;
         end
      end
   end
endmodule

// File: tb/tb_qupls_fpu_rs_queue.sv
// tb_qupls_fpu_rs_queue: directed checks of dispatch, snoop, select, flush and copy-target logic.
import qupls_fpu_rs_queue_pkg::*;
module tb_qupls_fpu_rs_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic disp_v, disp_rdy, flush, fu_idle, iss_v, aRtz, sc_done;
   rob_ndx_t disp_rndx, id;
   rob_entry_t disp_rob;
   value_t [3:0] disp_val;
   logic [3:0] disp_vld;
   pregno_t [3:0] disp_tag;
   value_t disp_argM, argA, argB, argC, argT, argM, argI;
   logic [1:0] byp_v;
   pregno_t [1:0] byp_tag;
   value_t [1:0] byp_val;
   checkpt_ndx_t flush_cp, cp;
   pregno_t Rt;
   aregno_t aRt;
   instruction_t instr;
   pc_address_t pc;
   logic [7:0] cptgt;
   logic [2:0] count;
   int nChecks = 0;
   int nFail = 0;

   qupls_fpu_rs_queue dut (
      .clk(clk), .rst(rst), .disp_v(disp_v), .disp_rdy(disp_rdy), .disp_rndx(disp_rndx),
      .disp_rob(disp_rob), .disp_val(disp_val), .disp_vld(disp_vld), .disp_tag(disp_tag),
      .disp_argM(disp_argM), .byp_v(byp_v), .byp_tag(byp_tag), .byp_val(byp_val),
      .flush(flush), .flush_cp(flush_cp), .fu_idle(fu_idle), .iss_v(iss_v), .id(id),
      .argA(argA), .argB(argB), .argC(argC), .argT(argT), .argM(argM), .argI(argI),
      .Rt(Rt), .aRt(aRt), .aRtz(aRtz), .instr(instr), .pc(pc), .cp(cp), .cptgt(cptgt),
      .sc_done(sc_done), .count(count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic disp(input rob_ndx_t r, input checkpt_ndx_t c, input logic [3:0] vld, input pregno_t t, input value_t a);
      disp_v = 1'b1;
      disp_rndx = r;
      disp_rob.cp = c;
      disp_vld = vld;
      for (int k = 0; k < 4; k++) begin
         disp_tag[k] = t;
         disp_val[k] = a + 64'(k);
      end
   endtask

   initial begin
      int sent, got;
      logic acc;
      disp_v = 0; disp_rndx = '0; disp_rob = '0; disp_val = '0; disp_vld = '0; disp_tag = '0;
      disp_argM = '0; byp_v = '0; byp_tag = '0; byp_val = '0; flush = 0; flush_cp = '0; fu_idle = 0;
      disp_rob.instr.opcode = OP_FPU;
      disp_rob.pc = 32'h1000;
      disp_rob.Rt = 8'h12;
      disp_rob.aRt = 6'h3;
      step; step;
      check("rst_iss", iss_v, 0);
      check("rst_sc", sc_done, 0);
      check("rst_count", count, 0);
      check("rst_rdy", disp_rdy, 1);
      check("rst_pc", pc, 64'hFFFD0000);
      check("rst_aRtz", aRtz, 1);
      check("rst_instr", instr, 64'h0B);
      check("rst_cptgt", cptgt, 0);
      check("rst_argA", argA, 0);
      rst = 0;

      fu_idle = 1;
      for (int k = 1; k <= 4; k++) begin
         disp(5'(k), 0, 4'hF, 0, 64'(k * 16));
         step;
         if (k > 1) begin
            check("t1_iss", iss_v, 1);
            check("t1_id", id, 64'(k - 1));
            check("t1_argA", argA, 64'((k - 1) * 16));
         end
         else check("t1_lat", iss_v, 0);
      end
      disp_v = 0;
      step;
      check("t1_iss4", iss_v, 1);
      check("t1_id4", id, 4);
      check("t1_pc", pc, 64'h1000);
      check("t1_count", count, 0);
      step;
      check("t1_empty", iss_v, 0);
      check("t1_hold", id, 4);

      disp(5, 0, 4'b1101, 8'h25, 64'h100);
      step;
      disp_v = 0;
      check("t2_count", count, 1);
      repeat (2) begin
         step;
         check("t2_wait", iss_v, 0);
      end
      byp_v = 2'b11;
      byp_tag[0] = 8'h11; byp_val[0] = 64'hDEAD;
      byp_tag[1] = 8'h25; byp_val[1] = 64'h3FF0_0000_0000_0000;
      step;
      byp_v = 0;
      check("t2_cap", iss_v, 0);
      step;
      check("t2_iss", iss_v, 1);
      check("t2_id", id, 5);
      check("t2_argB", argB, 64'h3FF0_0000_0000_0000);
      check("t2_argA", argA, 64'h100);
      check("t2_argC", argC, 64'h102);

      disp(6, 0, 4'b1011, 8'h30, 64'h200);
      step;
      disp_v = 0;
      byp_v = 2'b11;
      byp_tag[0] = 8'h30; byp_val[0] = 64'hAAAA;
      byp_tag[1] = 8'h30; byp_val[1] = 64'hBBBB;
      step;
      byp_v = 0;
      step;
      check("t2_low_id", id, 6);
      check("t2_low_argC", argC, 64'hAAAA);

      disp(7, 0, 4'b1110, 8'h40, 64'h300);
      byp_v = 2'b10; byp_tag[1] = 8'h40; byp_val[1] = 64'h77;
      step;
      disp_v = 0; byp_v = 0;
      step;
      check("t2_dw_id", id, 7);
      check("t2_dw_argA", argA, 64'h77);
      check("t2_dw_argB", argB, 64'h301);

      fu_idle = 0;
      for (int k = 0; k < 4; k++) begin
         disp(5'(8 + k), (k % 2) == 1 ? 3'd3 : 3'd2, 4'b1110, 8'h50, 64'h400 + 64'(k * 16));
         step;
      end
      disp_v = 0;
      check("t3_full_cnt", count, 4);
      check("t3_full_rdy", disp_rdy, 0);
      disp(12, 3, 4'hF, 0, 64'h999);
      step;
      disp_v = 0;
      check("t3_ignored", count, 4);
      flush = 1; flush_cp = 2;
      step;
      flush = 0;
      check("t3_flush_cnt", count, 2);
      check("t3_flush_rdy", disp_rdy, 1);
      byp_v = 2'b01; byp_tag[0] = 8'h50; byp_val[0] = 64'h55;
      step;
      byp_v = 0; fu_idle = 1;
      step;
      check("t3_iss_a", iss_v, 1);
      check("t3_id_a", id, 9);
      check("t3_argA", argA, 64'h55);
      check("t3_argB", argB, 64'h411);
      step;
      check("t3_id_b", id, 11);
      check("t3_cp_b", cp, 3);
      step;
      check("t3_done", iss_v, 0);
      check("t3_count", count, 0);

      disp(13, 2, 4'hF, 0, 0);
      flush = 1; flush_cp = 2;
      step;
      disp_v = 0; flush = 0;
      check("t3_fd_cnt", count, 0);
      step;
      check("t3_fd_iss", iss_v, 0);
      disp(14, 2, 4'hF, 0, 0);
      step;
      disp_v = 0;
      check("t3_fs_cnt1", count, 1);
      flush = 1;
      step;
      flush = 0;
      check("t3_fs_iss", iss_v, 0);
      check("t3_fs_cnt0", count, 0);
      check("t3_fs_hold", id, 11);

      disp_rob.vec = 1; disp_rob.cpytgt = 0; disp_rob.instr.Ra = 6'd1; disp_rob.multicycle = 1;
      disp_argM = 64'h0000_FF00;
      disp(15, 0, 4'hF, 0, 0);
      step;
      disp_v = 0;
      step;
      check("t4_iss", iss_v, 1);
      check("t4_cpt0", cptgt, 8'h00);
      check("t4_sc0", sc_done, 0);
      disp_argM = 0;
      disp(16, 0, 4'hF, 0, 0);
      step;
      disp_v = 0;
      step;
      check("t4_cptff", cptgt, 8'hFF);
      check("t4_sc1", sc_done, 1);
      disp_rob.vec = 0; disp_rob.cpytgt = 1; disp_argM = 64'h0000_FF00;
      disp(17, 0, 4'hF, 0, 0);
      step;
      disp_v = 0;
      step;
      check("t4_sv_cpt", cptgt, 8'hFF);
      check("t4_sv_sc", sc_done, 1);
      disp_rob.cpytgt = 0; disp_rob.multicycle = 0;
      disp(18, 0, 4'hF, 0, 0);
      step;
      disp_v = 0;
      step;
      check("t4_sc_cpt", cptgt, 8'h00);
      check("t4_sc_sc", sc_done, 1);
      step;
      check("t4_sc_pulse", sc_done, 0);

      sent = 0;
      got = 0;
      for (int c = 0; c < 200 && got < 10; c++) begin
         fu_idle = (c % 2) == 1;
         if (sent < 10) disp(5'(20 + sent), 1, 4'hF, 0, 64'(sent));
         else disp_v = 0;
         acc = disp_v && disp_rdy;
         step;
         if (acc) sent++;
         if (iss_v) begin
            check("t5_order", id, 64'(20 + got));
            got++;
         end
      end
      disp_v = 0;
      check("t5_all", got, 10);
      check("t5_count", count, 0);

      fu_idle = 0;
      disp(30, 1, 4'b1110, 8'h60, 0);
      step;
      disp(31, 1, 4'b1110, 8'h60, 0);
      step;
      disp_v = 0;
      check("t6_pre", count, 2);
      rst = 1;
      step;
      rst = 0;
      check("t6_count", count, 0);
      check("t6_rdy", disp_rdy, 1);
      check("t6_iss", iss_v, 0);
      check("t6_pc", pc, 64'hFFFD0000);

      $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
      $finish;
   end
endmodule
